// File: rtl/shufflenetv2_acc_requant_if.sv
// shufflenetv2_acc_requant_if: product input stream and activation output stream.
interface shufflenetv2_acc_requant_if #(parameter int PROD_W = 22);
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_prod;
    logic [4:0]        in_shift;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_data;
    modport slave (
        input  in_valid, in_prod, in_shift, out_ready,
        output in_ready, out_valid, out_data
    );
    modport master (
        output in_valid, in_prod, in_shift, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/shufflenetv2_acc_requant.sv
// shufflenetv2_acc_requant: sums ACC_LEN products, round-half-up shifts, saturates to u8.
module shufflenetv2_acc_requant #(
    parameter int ACC_LEN = 9,
    parameter int PROD_W  = 22,
    parameter int ACC_W   = 26
) (
    input logic                       ap_clk,
    input logic                       ap_rst,
    shufflenetv2_acc_requant_if.slave io
);
    localparam int CNT_W = ACC_LEN > 1 ? $clog2(ACC_LEN) : 1;
    typedef enum logic {ACC, HOLD} state_t;
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [ACC_W-1:0] acc_q;
    logic             out_valid_q;
    logic [7:0]       out_data_q;
    logic             accept;
    logic             last;
    logic [4:0]       sh;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W:0]   bias;
    logic [ACC_W:0]   shifted;
    logic [ACC_W:0]   r;
    logic [7:0]       out_data_d;
    assign io.in_ready  = (state_q == ACC);
    assign io.out_valid = out_valid_q;
    assign io.out_data  = out_data_q;
    assign accept = io.in_valid && io.in_ready;
    assign last   = (cnt_q == CNT_W'(ACC_LEN - 1));
    assign sh     = io.in_shift;
    // first product of a window loads instead of adding, so no clear cycle is needed
    assign acc_d      = ((cnt_q == '0) ? '0 : acc_q) + ACC_W'(io.in_prod);
    assign bias       = (sh == 5'd0) ? '0 : ((ACC_W+1)'(1) << (sh - 5'd1));
    assign shifted    = ({1'b0, acc_d} + bias) >> sh;
    assign r          = (32'(sh) >= ACC_W) ? '0 : shifted;
    assign out_data_d = (r > (ACC_W+1)'(255)) ? 8'hff : r[7:0];
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q     <= ACC;
            cnt_q       <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            if (accept) begin
                acc_q <= acc_d;
                if (last) begin
                    cnt_q       <= '0;
                    out_data_q  <= out_data_d;
                    out_valid_q <= 1'b1;
                    state_q     <= HOLD;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
            if (state_q == HOLD && io.out_ready) begin
                out_valid_q <= 1'b0;
                state_q     <= ACC;
            end
        end
    end
endmodule

// File: tb/tb_shufflenetv2_acc_requant.sv
// tb_shufflenetv2_acc_requant: directed checks of accumulation, rounding, saturation and handshakes.
module tb_shufflenetv2_acc_requant;
    logic ap_clk = 1'b0;
    logic ap_rst = 1'b1;
    int compared = 0;
    int mismatched = 0;
    shufflenetv2_acc_requant_if #(.PROD_W(22)) bus ();
    shufflenetv2_acc_requant #(.ACC_LEN(9), .PROD_W(22), .ACC_W(26)) dut (
        .ap_clk(ap_clk),
        .ap_rst(ap_rst),
        .io(bus.slave)
    );
    always #5 ap_clk = ~ap_clk;
    task automatic push(input logic [21:0] p, input logic [4:0] s);
        int n = 0;
        @(negedge ap_clk);
        while (!bus.in_ready && n < 20) begin
            @(negedge ap_clk);
            n++;
        end
        if (!bus.in_ready) begin
            compared++;
            mismatched++;
            $display("FAIL push_timeout in_ready=0 required 1");
        end
        bus.in_valid = 1'b1;
        bus.in_prod  = p;
        bus.in_shift = s;
        @(posedge ap_clk);
        #1 bus.in_valid = 1'b0;
    endtask
    task automatic feed(input logic [21:0] p, input int n, input logic [4:0] s);
        for (int i = 0; i < n; i++) push(p, s);
    endtask
    task automatic drain();
        @(negedge ap_clk);
        bus.out_ready = 1'b1;
        @(posedge ap_clk);
        #1 bus.out_ready = 1'b0;
    endtask
    task automatic test_reset();
        bus.in_valid = 1'b0; bus.in_prod = '0; bus.in_shift = '0; bus.out_ready = 1'b0;
        #2;
        compared++;
        if (bus.out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid got %0b want 0", bus.out_valid); end
        @(negedge ap_clk);
        ap_rst = 1'b0;
        @(negedge ap_clk);
        compared += 3;
        if (bus.in_ready !== 1'b1) begin mismatched++; $display("FAIL reset_in_ready got %0b want 1", bus.in_ready); end
        if (bus.out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid_post got %0b want 0", bus.out_valid); end
        if (bus.out_data !== 8'd0) begin mismatched++; $display("FAIL reset_out_data got %0d want 0", bus.out_data); end
    endtask
    task automatic test_basic();
        feed(22'd1, 8, 5'd0);
        @(negedge ap_clk);
        compared++;
        if (bus.out_valid !== 1'b0) begin mismatched++; $display("FAIL basic_early_valid got %0b want 0", bus.out_valid); end
        push(22'd1, 5'd0);
        @(negedge ap_clk);
        compared += 3;
        if (bus.out_valid !== 1'b1) begin mismatched++; $display("FAIL basic_valid got %0b want 1", bus.out_valid); end
        if (bus.out_data !== 8'd9) begin mismatched++; $display("FAIL basic_data got %0d want 9", bus.out_data); end
        if (bus.in_ready !== 1'b0) begin mismatched++; $display("FAIL basic_hold_ready got %0b want 0", bus.in_ready); end
        drain();
    endtask
    task automatic test_rounding();
        feed(22'd100, 9, 5'd2);
        @(negedge ap_clk);
        compared++;
        if (bus.out_data !== 8'd225) begin mismatched++; $display("FAIL round_900 got %0d want 225", bus.out_data); end
        drain();
        push(22'd6, 5'd2);
        feed(22'd0, 8, 5'd2);
        @(negedge ap_clk);
        compared++;
        if (bus.out_data !== 8'd2) begin mismatched++; $display("FAIL round_tie got %0d want 2", bus.out_data); end
        drain();
    endtask
    task automatic test_saturation();
        logic [4:0] shs [4] = '{5'd0, 5'd31, 5'd25, 5'd26};
        logic [7:0] exp [4] = '{8'd255, 8'd0, 8'd1, 8'd0};
        for (int k = 0; k < 4; k++) begin
            feed(22'd4189185, 9, shs[k]);
            @(negedge ap_clk);
            compared++;
            if (bus.out_data !== exp[k]) begin mismatched++; $display("FAIL sat_shift%0d got %0d want %0d", shs[k], bus.out_data, exp[k]); end
            drain();
        end
    endtask
    task automatic test_backpressure();
        feed(22'd1, 9, 5'd0);
        for (int c = 0; c < 5; c++) begin
            @(negedge ap_clk);
            compared += 3;
            if (bus.out_valid !== 1'b1) begin mismatched++; $display("FAIL bp_valid cyc%0d got %0b want 1", c, bus.out_valid); end
            if (bus.out_data !== 8'd9) begin mismatched++; $display("FAIL bp_data cyc%0d got %0d want 9", c, bus.out_data); end
            if (bus.in_ready !== 1'b0) begin mismatched++; $display("FAIL bp_ready cyc%0d got %0b want 0", c, bus.in_ready); end
        end
        drain();
        @(negedge ap_clk);
        compared += 2;
        if (bus.out_valid !== 1'b0) begin mismatched++; $display("FAIL bp_release_valid got %0b want 0", bus.out_valid); end
        if (bus.in_ready !== 1'b1) begin mismatched++; $display("FAIL bp_release_ready got %0b want 1", bus.in_ready); end
    endtask
    task automatic test_gapped();
        for (int i = 0; i < 8; i++) begin
            push(22'd3, 5'(i + 3));
            @(negedge ap_clk);
        end
        push(22'd3, 5'd1);
        @(negedge ap_clk);
        compared++;
        if (bus.out_data !== 8'd14) begin mismatched++; $display("FAIL gapped got %0d want 14", bus.out_data); end
        drain();
    endtask
    task automatic test_reset_mid();
        feed(22'd50, 4, 5'd0);
        #2 ap_rst = 1'b1;
        #1;
        compared += 2;
        if (bus.out_valid !== 1'b0) begin mismatched++; $display("FAIL midrst_valid got %0b want 0", bus.out_valid); end
        if (bus.in_ready !== 1'b1) begin mismatched++; $display("FAIL midrst_ready got %0b want 1", bus.in_ready); end
        @(negedge ap_clk);
        ap_rst = 1'b0;
        feed(22'd1, 8, 5'd0);
        @(negedge ap_clk);
        compared++;
        if (bus.out_valid !== 1'b0) begin mismatched++; $display("FAIL midrst_stale_window got %0b want 0", bus.out_valid); end
        push(22'd1, 5'd0);
        @(negedge ap_clk);
        compared++;
        if (bus.out_data !== 8'd9) begin mismatched++; $display("FAIL midrst_data got %0d want 9", bus.out_data); end
        drain();
    endtask
    task automatic test_back_to_back();
        bus.out_ready = 1'b1;
        feed(22'd2, 9, 5'd0);
        @(negedge ap_clk);
        compared += 2;
        if (bus.out_valid !== 1'b1) begin mismatched++; $display("FAIL b2b_valid1 got %0b want 1", bus.out_valid); end
        if (bus.out_data !== 8'd18) begin mismatched++; $display("FAIL b2b_data1 got %0d want 18", bus.out_data); end
        bus.out_ready = 1'b1;
        feed(22'd5, 9, 5'd1);
        @(negedge ap_clk);
        compared += 2;
        if (bus.out_valid !== 1'b1) begin mismatched++; $display("FAIL b2b_valid2 got %0b want 1", bus.out_valid); end
        if (bus.out_data !== 8'd23) begin mismatched++; $display("FAIL b2b_data2 got %0d want 23", bus.out_data); end
        @(negedge ap_clk);
        compared++;
        if (bus.out_valid !== 1'b0) begin mismatched++; $display("FAIL b2b_drained got %0b want 0", bus.out_valid); end
        bus.out_ready = 1'b0;
    endtask
    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_saturation();
        test_backpressure();
        test_gapped();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/shufflenetv2_acc_requant.md
# shufflenetv2_acc_requant

Downstream consumer of the ShuffleNetV2 unsigned 12x10 multiplier, which produces 22-bit products. It accumulates a fixed number of consecutive products (one convolution window, 3x3 depthwise by default), applies a round-half-up right shift and saturates the result to the 8-bit unsigned activation format used between layers. Products arrive on a valid/ready input stream and results leave on a valid/ready output stream.

## Interface
- ACC_LEN, 9: products summed per output, 1..256.
- PROD_W, 22: product width; must match the multiplier output.
- ACC_W, 26: accumulator width; must satisfy ACC_W >= PROD_W + ceil(log2(ACC_LEN)).
- ap_clk  in  1  clock; all state changes on the rising edge.
- ap_rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_prod and in_shift are valid.
- in_ready  out  1  block accepts an input this cycle.
- in_prod  in  PROD_W  unsigned product.
- in_shift  in  5  right-shift amount; sampled only with the last product of a window.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  8  saturated unsigned result.

## Operation
- The FSM has two states: ACC and HOLD. Reset state is ACC.
- Reset values: state=ACC, cnt=0, acc=0, out_valid=0, out_data=0. in_ready=1 after reset.
- in_ready = (state==ACC). It is combinational from state only and does not depend on in_valid.
- Accept = in_valid && in_ready.
- Accept with cnt==0: acc <= in_prod, so no clear cycle is needed. Accept with cnt>0: acc <= acc + in_prod.
- Each accept increments cnt. The accept with cnt==ACC_LEN-1 is the last product of the window:
  - sum = acc + in_prod (ACC_W bits, cannot overflow given the ACC_W constraint);
  - r = (sh==0) ? sum : (sum + 2^(sh-1)) >> sh, computed in ACC_W+1 bits, where sh = in_shift sampled on this same cycle;
  - if sh >= ACC_W, r = 0;
  - out_data <= min(r, 255);
  - out_valid <= 1, cnt <= 0, state <= HOLD.
- In HOLD, in_ready=0. out_data and out_valid are held stable until out_ready=1. On that cycle: out_valid <= 0 and state <= ACC.
- Accepts with in_valid=0 do not occur. Gaps between products are allowed and do not change acc or cnt.
- All arithmetic is unsigned. No sign extension anywhere.

## Timing
- Latency: last product accepted at edge t, so out_valid=1 and out_data are valid after edge t. They are visible in cycle t+1.
- The output handshake completes at the edge where out_valid && out_ready. in_ready returns to 1 in the following cycle. This gives one idle input cycle per window.
- Peak throughput is ACC_LEN products per ACC_LEN+1 cycles when out_ready is held at 1.
- out_ready=1 while out_valid=0 has no effect.
- ap_rst asserted mid-window or in HOLD discards the partial sum and any pending output immediately (asynchronously). After deassertion the next accepted product starts a new window with cnt==0.
- ACC_LEN==1: every accept is both first and last, so acc is unused and out_data is derived directly from in_prod.

## Test plan
- Basic sum: ACC_LEN=9, nine products of 1, in_shift=0 -> out_data=9, out_valid rises one cycle after the 9th accept.
- Rounding: nine products of 100, in_shift=2 -> (900+2)>>2=225. Tie case: products {6,0,0,0,0,0,0,0,0}, in_shift=2 -> (6+2)>>2=2.
- Saturation and shift limit: nine products of 4189185, in_shift=0 -> out_data=255. Same window with in_shift=31 -> out_data=0.
- Backpressure: after a window completes, hold out_ready=0 for 5 cycles -> out_data stable, out_valid=1, in_ready=0 throughout. Raise out_ready -> out_valid=0 next cycle, in_ready=1.
- Gapped input: nine products of 3 with in_valid toggling every other cycle, in_shift=1 -> (27+1)>>1=14. Only the in_shift value present on the 9th accept is used; in_shift changes during earlier accepts have no effect.
- Reset mid-window: accept 4 products of 50, pulse ap_rst, then nine products of 1 at in_shift=0 -> out_data=9, and no output is produced for the aborted window.
